// File: rtl/uart_ctrl_pkg.sv
// Shared constants and state encodings for the uart_ctrl register block.
package uart_ctrl_pkg;

   localparam logic [1:0] ADDR_TXDATA = 2'd0;
   localparam logic [1:0] ADDR_RXDATA = 2'd1;
   localparam logic [1:0] ADDR_STATUS = 2'd2;
   localparam logic [1:0] ADDR_CTRL   = 2'd3;

   localparam int ST_TX_EMPTY = 0;
   localparam int ST_TX_FULL  = 1;
   localparam int ST_RX_AVAIL = 2;
   localparam int ST_RX_FULL  = 3;
   localparam int ST_OVERRUN  = 4;
   localparam int ST_TX_DROP  = 5;

   localparam int CTRL_RX_IRQ_EN = 0;
   localparam int CTRL_TX_IRQ_EN = 1;
   localparam int CTRL_LOOP_EN   = 2;
   localparam int CTRL_CLR_ERR   = 31;

   localparam logic [2:0] WAIT_HI_TIMEOUT = 3'd4;

   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_WAIT_HI, TX_WAIT_LO} tx_state_e;
   typedef enum logic [1:0] {RX_IDLE, RX_CLEAR, RX_DRAIN} rx_state_e;

endpackage

// File: rtl/uart_ctrl_if.sv
// CPU-side register bus of uart_ctrl: single-cycle strobes, registered read data.
interface uart_ctrl_if;
   logic [1:0]  addr;
   logic        wr_en;
   logic        rd_en;
   logic [31:0] wdata;
   logic [31:0] rdata;

   modport master (output addr, output wr_en, output rd_en, output wdata, input rdata);
   modport slave  (input addr, input wr_en, input rd_en, input wdata, output rdata);
endinterface

// File: rtl/uart_ctrl_sync_fifo.sv
// sync_fifo: registered-storage FIFO; head shows the oldest entry, pop advances it.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] head,
   output logic             empty,
   output logic             full
);
   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

   logic [PW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
   logic [PW:0]    count_q, count_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic do_push, do_pop;

   always_comb begin
      do_pop  = pop && (count_q != '0);
      do_push = push && ((count_q != FULL_CNT) || do_pop);
      wptr_d  = do_push ? wptr_q + 1'b1 : wptr_q;
      rptr_d  = do_pop  ? rptr_q + 1'b1 : rptr_q;
      count_d = count_q;
      if (do_push && !do_pop) count_d = count_q + 1'b1;
      if (do_pop && !do_push) count_d = count_q - 1'b1;
      mem_d = mem_q;
      if (do_push) mem_d[wptr_q] = din;
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
      if (rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   assign head  = mem_q[rptr_q];
   assign empty = (count_q == '0);
   assign full  = (count_q == FULL_CNT);
endmodule

// File: rtl/uart_ctrl.sv
// uart_ctrl: register-mapped TX/RX buffering and handshake sequencing for the uart.
// Build option UART_CTRL_LOOPBACK_EN adds CTRL bit2 (loop_en) routing TX bytes into the RX FIFO.
module uart_ctrl
   import uart_ctrl_pkg::*;
#(
   parameter int TX_DEPTH = 8,
   parameter int RX_DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   uart_ctrl_if.slave       bus,
   output logic [7:0]       uart_tx_data,
   output logic             uart_tx_en,
   input  logic             uart_tx_busy,
   input  logic             uart_rx_ready,
   input  logic [7:0]       uart_rx_data,
   output logic             uart_rx_clear,
   output logic             irq
);
   tx_state_e   tx_state_q, tx_state_d;
   rx_state_e   rx_state_q, rx_state_d;
   logic [2:0]  hi_cnt_q, hi_cnt_d;
   logic [7:0]  tx_data_q, tx_data_d;
   logic [1:0]  ctrl_q, ctrl_d;
   logic        overrun_q, overrun_d, tx_drop_q, tx_drop_d, irq_q, irq_d;
   logic [31:0] rdata_q, rdata_d;

   logic        tx_push, tx_pop, tx_empty, tx_full;
   logic [7:0]  tx_head;
   logic        rx_push, rx_pop, rx_empty, rx_full, rx_push_req, rx_lost, rx_capture;
   logic [7:0]  rx_head, rx_din;
   logic        wr_tx, wr_ctrl, rd_rx;
   logic        unused_wdata;

`ifdef UART_CTRL_LOOPBACK_EN
   logic loop_q, loop_d;
   logic loop_en;
   assign loop_en = loop_q;
`else
   localparam logic loop_en = 1'b0;
`endif

   assign unused_wdata = ^bus.wdata[30:8];
   assign wr_tx   = bus.wr_en && (bus.addr == ADDR_TXDATA);
   assign wr_ctrl = bus.wr_en && (bus.addr == ADDR_CTRL);
   assign rd_rx   = bus.rd_en && (bus.addr == ADDR_RXDATA);

   sync_fifo #(.DEPTH(TX_DEPTH), .WIDTH(8)) u_tx_fifo (
      .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop), .din(bus.wdata[7:0]),
      .head(tx_head), .empty(tx_empty), .full(tx_full)
   );

   sync_fifo #(.DEPTH(RX_DEPTH), .WIDTH(8)) u_rx_fifo (
      .clk(clk), .rst(rst), .push(rx_push), .pop(rx_pop), .din(rx_din),
      .head(rx_head), .empty(rx_empty), .full(rx_full)
   );

   // FSM outputs and FIFO strobes
   always_comb begin
      tx_pop        = (tx_state_q == TX_IDLE) && !tx_empty && !uart_tx_busy;
      uart_tx_en    = (tx_state_q == TX_START) && !loop_en;
      rx_capture    = (rx_state_q == RX_IDLE) && uart_rx_ready && !loop_en;
      uart_rx_clear = (rx_state_q == RX_CLEAR);
      tx_push       = wr_tx && !tx_full;
      rx_pop        = rd_rx && !rx_empty;
      rx_push_req   = rx_capture || (tx_pop && loop_en);
      rx_din        = loop_en ? tx_head : uart_rx_data;
      rx_push       = rx_push_req && (!rx_full || rx_pop);
      rx_lost       = rx_push_req && rx_full && !rx_pop;
   end

   // FSM next state
   always_comb begin
      tx_state_d = tx_state_q;
      hi_cnt_d   = hi_cnt_q;
      tx_data_d  = tx_data_q;
      rx_state_d = rx_state_q;
      case (tx_state_q)
         TX_IDLE: if (tx_pop) begin
            tx_data_d  = tx_head;
            tx_state_d = TX_START;
         end
         TX_START: begin
            hi_cnt_d   = '0;
            tx_state_d = loop_en ? TX_IDLE : TX_WAIT_HI;
         end
         TX_WAIT_HI: begin
            if (uart_tx_busy || (hi_cnt_q == WAIT_HI_TIMEOUT - 3'd1)) tx_state_d = TX_WAIT_LO;
            else hi_cnt_d = hi_cnt_q + 3'd1;
         end
         TX_WAIT_LO: if (!uart_tx_busy) tx_state_d = TX_IDLE;
         default: tx_state_d = TX_IDLE;
      endcase
      case (rx_state_q)
         RX_IDLE:  if (rx_capture) rx_state_d = RX_CLEAR;
         RX_CLEAR: rx_state_d = RX_DRAIN;
         RX_DRAIN: if (!uart_rx_ready) rx_state_d = RX_IDLE;
         default:  rx_state_d = RX_IDLE;
      endcase
   end

   // Registers, sticky flags and read mux; an error set in the clearing cycle survives
   always_comb begin
      ctrl_d    = ctrl_q;
      overrun_d = overrun_q;
      tx_drop_d = tx_drop_q;
`ifdef UART_CTRL_LOOPBACK_EN
      loop_d    = loop_q;
      if (wr_ctrl) loop_d = bus.wdata[CTRL_LOOP_EN];
`endif
      if (wr_ctrl) begin
         ctrl_d = bus.wdata[1:0];
         if (bus.wdata[CTRL_CLR_ERR]) begin
            overrun_d = 1'b0;
            tx_drop_d = 1'b0;
         end
      end
      if (rx_lost) overrun_d = 1'b1;
      if (wr_tx && tx_full) tx_drop_d = 1'b1;
      rdata_d = rdata_q;
      if (bus.rd_en) begin
         case (bus.addr)
            ADDR_RXDATA: rdata_d = rx_empty ? 32'd0 : {24'd0, rx_head};
            ADDR_STATUS: rdata_d = {26'd0, tx_drop_q, overrun_q, rx_full, !rx_empty,
                                    tx_full, tx_empty};
            ADDR_CTRL:   rdata_d = {29'd0, loop_en, ctrl_q};
            default:     rdata_d = 32'd0;
         endcase
      end
      irq_d = (ctrl_q[CTRL_RX_IRQ_EN] && !rx_empty)
            || (ctrl_q[CTRL_TX_IRQ_EN] && tx_empty && (tx_state_q == TX_IDLE))
            || overrun_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_state_q <= TX_IDLE;
         rx_state_q <= RX_IDLE;
         hi_cnt_q   <= '0;
         tx_data_q  <= '0;
         ctrl_q     <= '0;
         overrun_q  <= 1'b0;
         tx_drop_q  <= 1'b0;
         irq_q      <= 1'b0;
         rdata_q    <= '0;
`ifdef UART_CTRL_LOOPBACK_EN
         loop_q     <= 1'b0;
`endif
      end else begin
         tx_state_q <= tx_state_d;
         rx_state_q <= rx_state_d;
         hi_cnt_q   <= hi_cnt_d;
         tx_data_q  <= tx_data_d;
         ctrl_q     <= ctrl_d;
         overrun_q  <= overrun_d;
         tx_drop_q  <= tx_drop_d;
         irq_q      <= irq_d;
         rdata_q    <= rdata_d;
`ifdef UART_CTRL_LOOPBACK_EN
         loop_q     <= loop_d;
`endif
      end
   end

   assign uart_tx_data = tx_data_q;
   assign irq          = irq_q;
   assign bus.rdata    = rdata_q;
endmodule

// File: tb/tb_uart_ctrl.sv
// Scoreboard bench for uart_ctrl: directed scenarios plus a randomized phase,
// checked against a queue-based model of the register/FIFO rules.
module tb_uart_ctrl;
   import uart_ctrl_pkg::*;

   localparam int DEPTH = 8;

   typedef struct {
      logic [95:0] name;
      logic [31:0] act;
      logic [31:0] exp;
   } chk_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [7:0] uart_tx_data;
   logic uart_tx_en, uart_tx_busy, uart_rx_ready, uart_rx_clear, irq;
   logic [7:0] uart_rx_data;
   logic busy_model = 1'b0;
   logic busy_stuck = 1'b0;
   logic busy_rand  = 1'b0;
   int   busy_len   = 20;

   uart_ctrl_if bus();

   uart_ctrl #(.TX_DEPTH(DEPTH), .RX_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .bus(bus),
      .uart_tx_data(uart_tx_data), .uart_tx_en(uart_tx_en), .uart_tx_busy(uart_tx_busy),
      .uart_rx_ready(uart_rx_ready), .uart_rx_data(uart_rx_data),
      .uart_rx_clear(uart_rx_clear), .irq(irq)
   );

   always #5 clk = ~clk;
   assign uart_tx_busy = busy_model | busy_stuck;

   // Scoreboard state and reference model
   logic [7:0]  exp_tx[$];
   logic [31:0] exp_rd[$];
   chk_t        chk_q[$];
   logic [7:0]  rxq[$];
   logic        m_overrun = 1'b0, m_tx_drop = 1'b0;
   logic [1:0]  m_ctrl = 2'b00;
   int n_checks = 0, n_errs = 0, tx_en_cnt = 0, clr_cnt = 0;
   logic rd_pend = 1'b0;
   chk_t mc;
   logic [31:0] me;

   task automatic cmp(input logic [95:0] nm, input logic [31:0] a, input logic [31:0] e);
      n_checks++;
      if (a !== e) begin
         n_errs++;
         $display("FAIL %0s: actual=%h required=%h at %0t", nm, a, e, $time);
      end
   endtask

   task automatic rec(input logic [95:0] nm, input logic [31:0] a, input logic [31:0] e);
      chk_q.push_back('{nm, a, e});
   endtask

   // Behavioural uart transmitter: busy rises one cycle after tx_en
   initial begin
      int len;
      forever begin
         @(negedge clk);
         if (uart_tx_en) begin
            len = busy_rand ? int'($urandom_range(0, 6)) : busy_len;
            if (len > 0) begin
               @(negedge clk);
               busy_model = 1'b1;
               repeat (len) @(negedge clk);
               busy_model = 1'b0;
            end
         end
      end
   end

   always @(posedge clk) rd_pend <= bus.rd_en;

   // Monitor: the only place comparisons are evaluated and counted
   always @(negedge clk) begin
      if (uart_tx_en) begin
         tx_en_cnt++;
         if (exp_tx.size() != 0) me = {24'd0, exp_tx.pop_front()};
         else me = 32'hFFFF_FFFF;
         cmp("tx_data", {24'd0, uart_tx_data}, me);
         cmp("busy_at_en", {31'd0, uart_tx_busy}, 32'd0);
      end
      if (uart_rx_clear) clr_cnt++;
      if (rd_pend) begin
         if (exp_rd.size() != 0) me = exp_rd.pop_front();
         else me = 32'hDEAD_BEEF;
         cmp("rdata", bus.rdata, me);
      end
      while (chk_q.size() != 0) begin
         mc = chk_q.pop_front();
         cmp(mc.name, mc.act, mc.exp);
      end
   end

   function automatic logic [31:0] exp_status(input logic txe, input logic txf);
      return {26'd0, m_tx_drop, m_overrun, rxq.size() == DEPTH, rxq.size() != 0, txf, txe};
   endfunction

   // Directed checks assume the transmitter is idle with an empty TX FIFO
   function automatic logic [31:0] exp_irq_idle();
      return {31'd0, (m_ctrl[0] && rxq.size() != 0) || m_ctrl[1] || m_overrun};
   endfunction

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      @(posedge clk); #1;
      bus.addr = a; bus.wdata = d; bus.wr_en = 1'b1;
      @(posedge clk); #1;
      bus.wr_en = 1'b0;
   endtask

   task automatic bus_read(input logic [1:0] a, input logic [31:0] e);
      @(posedge clk); #1;
      bus.addr = a; bus.rd_en = 1'b1;
      exp_rd.push_back(e);
      @(posedge clk); #1;
      bus.rd_en = 1'b0;
   endtask

   task automatic tx_write(input logic [7:0] b);
      exp_tx.push_back(b);
      bus_write(ADDR_TXDATA, {24'd0, b});
   endtask

   task automatic rx_read();
      logic [31:0] e;
      e = (rxq.size() != 0) ? {24'd0, rxq.pop_front()} : 32'd0;
      bus_read(ADDR_RXDATA, e);
   endtask

   task automatic ctrl_write(input logic [31:0] w);
      m_ctrl = w[1:0];
      if (w[31]) begin
         m_overrun = 1'b0;
         m_tx_drop = 1'b0;
      end
      bus_write(ADDR_CTRL, w);
   endtask

   task automatic rx_send(input logic [7:0] d);
      int t;
      @(posedge clk); #1;
      uart_rx_ready = 1'b1; uart_rx_data = d;
      t = 0;
      do begin @(negedge clk); t++; end while (!uart_rx_clear && t < 10);
      rec("rx_clear", {31'd0, uart_rx_clear}, 32'd1);
      repeat (3) @(posedge clk);
      #1 uart_rx_ready = 1'b0; uart_rx_data = 8'($urandom);
      repeat (2) @(posedge clk);
      if (rxq.size() < DEPTH) rxq.push_back(d);
      else m_overrun = 1'b1;
   endtask

   task automatic wait_tx_done();
      int t;
      t = 0;
      while (exp_tx.size() != 0 && t < 3000) begin @(negedge clk); t++; end
      rec("tx_drain", exp_tx.size(), 32'd0);
      repeat (3) @(negedge clk);
      t = 0;
      while (uart_tx_busy && t < 100) begin @(negedge clk); t++; end
      repeat (8) @(negedge clk);
   endtask

   task automatic check_reset_outputs();
      rec("rst_rdata", bus.rdata, 32'd0);
      rec("rst_txdata", {24'd0, uart_tx_data}, 32'd0);
      rec("rst_txen", {31'd0, uart_tx_en}, 32'd0);
      rec("rst_rxclr", {31'd0, uart_rx_clear}, 32'd0);
      rec("rst_irq", {31'd0, irq}, 32'd0);
   endtask

   task automatic model_reset();
      rxq.delete();
      exp_tx.delete();
      m_overrun = 1'b0; m_tx_drop = 1'b0; m_ctrl = 2'b00;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: time=%0t limit=500000", $time);
      $fatal(1);
   end

   initial begin
      int base, op, t;
      logic [31:0] w;
      bus.addr = '0; bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.wdata = '0;
      uart_rx_ready = 1'b0; uart_rx_data = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_reset_outputs();
      bus_read(ADDR_STATUS, 32'h1);
      bus_read(ADDR_CTRL, 32'h0);
      rx_read();

      // Three bytes, uart busy for 20 cycles each
      base = tx_en_cnt;
      tx_write(8'h41); tx_write(8'h42); tx_write(8'h43);
      wait_tx_done();
      rec("tx_cnt3", tx_en_cnt - base, 32'd3);

      // Nine writes while busy is stuck: eight accepted, one dropped
      busy_stuck = 1'b1;
      base = tx_en_cnt;
      for (int i = 0; i < 9; i++) begin
         if (i < DEPTH) tx_write(8'h60 + 8'(i));
         else begin
            m_tx_drop = 1'b1;
            bus_write(ADDR_TXDATA, 32'h0000_00EE);
         end
      end
      bus_read(ADDR_STATUS, exp_status(1'b0, 1'b1));
      busy_stuck = 1'b0;
      wait_tx_done();
      rec("tx_cnt8", tx_en_cnt - base, 32'd8);
      ctrl_write(32'h8000_0000);
      bus_read(ADDR_STATUS, exp_status(1'b1, 1'b0));

      // One received byte held long after rx_clear is captured once
      base = clr_cnt;
      rx_send(8'h5A);
      rec("clr_cnt1", clr_cnt - base, 32'd1);
      rx_read();
      rx_read();
      bus_read(ADDR_STATUS, exp_status(1'b1, 1'b0));

      // Overrun on the ninth byte
      for (int i = 0; i < 9; i++) rx_send(8'($urandom));
      repeat (3) @(negedge clk);
      rec("irq_ovr", {31'd0, irq}, exp_irq_idle());
      bus_read(ADDR_STATUS, exp_status(1'b1, 1'b0));
      ctrl_write(32'h8000_0000);
      repeat (3) @(negedge clk);
      rec("irq_clr", {31'd0, irq}, exp_irq_idle());
      bus_read(ADDR_STATUS, exp_status(1'b1, 1'b0));
      for (int i = 0; i < DEPTH + 1; i++) rx_read();

      // Interrupt enables and CTRL readback
      ctrl_write(32'h2);
      repeat (3) @(negedge clk);
      rec("irq_tx", {31'd0, irq}, exp_irq_idle());
      ctrl_write(32'h1);
      repeat (3) @(negedge clk);
      rec("irq_rx0", {31'd0, irq}, exp_irq_idle());
      rx_send(8'hC3);
      repeat (2) @(negedge clk);
      rec("irq_rx1", {31'd0, irq}, exp_irq_idle());
      rx_read();
      repeat (3) @(negedge clk);
      rec("irq_rx2", {31'd0, irq}, exp_irq_idle());
      ctrl_write(32'h7);
`ifdef UART_CTRL_LOOPBACK_EN
      bus_read(ADDR_CTRL, 32'h7);
`else
      bus_read(ADDR_CTRL, 32'h3);
`endif
      ctrl_write(32'h0);

      // Randomized mix of traffic; uart busy length random, 0 exercises the timeout
      busy_rand = 1'b1;
      base = tx_en_cnt;
      t = 0;
      for (int i = 0; i < 80; i++) begin
         op = int'($urandom_range(0, 3));
         case (op)
            0: if (exp_tx.size() < 6) begin
               tx_write(8'($urandom));
               t++;
            end
            1: rx_send(8'($urandom));
            2: rx_read();
            default: begin
               w = $urandom;
               w[CTRL_LOOP_EN] = 1'b0;
               ctrl_write(w);
               bus_read(ADDR_CTRL, {30'd0, w[1:0]});
            end
         endcase
      end
      wait_tx_done();
      rec("rand_txcnt", tx_en_cnt - base, t);
      while (rxq.size() != 0) rx_read();
      rx_read();
      ctrl_write(32'h8000_0000);
      busy_rand = 1'b0;

      // Reset while waiting for busy to fall
      busy_len = 20;
      tx_write(8'h77);
      t = 0;
      while (exp_tx.size() != 0 && t < 50) begin @(negedge clk); t++; end
      rec("wlo_txen", exp_tx.size(), 32'd0);
      repeat (4) @(negedge clk);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      model_reset();
      check_reset_outputs();
      bus_read(ADDR_STATUS, 32'h1);
      t = 0;
      while (uart_tx_busy && t < 100) begin @(negedge clk); t++; end

      // Reset during the rx_clear pulse abandons the byte
      @(posedge clk); #1;
      uart_rx_ready = 1'b1; uart_rx_data = 8'h3C;
      t = 0;
      do begin @(negedge clk); t++; end while (!uart_rx_clear && t < 10);
      rec("clr_seen", {31'd0, uart_rx_clear}, 32'd1);
      uart_rx_ready = 1'b0; rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      model_reset();
      check_reset_outputs();
      bus_read(ADDR_STATUS, 32'h1);
      rx_read();

`ifdef UART_CTRL_LOOPBACK_EN
      base = tx_en_cnt;
      bus_write(ADDR_CTRL, 32'h4);
      bus_write(ADDR_TXDATA, 32'h99);
      rxq.push_back(8'h99);
      repeat (10) @(negedge clk);
      rec("loop_txen", tx_en_cnt - base, 32'd0);
      rx_read();
      rx_read();
      ctrl_write(32'h0);
`endif

      repeat (4) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end
endmodule
